// File: rtl/pipeline_ctrl.sv
// Hazard and pipeline-control unit for the five-stage RV64 core: per-stage stall/flush,
// PC redirect selection, a small wait/shadow FSM, and a stall-cycle performance counter.
module pipeline_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    input  logic             we_csr_id,
    input  logic             valid_exe,
    input  logic             is_load_exe,
    input  logic             we_csr_exe,
    input  logic [4:0]       rd_exe,
    input  logic             mispredict_exe,
    input  logic             valid_mem,
    input  logic             we_csr_mem,
    input  logic             dmem_req_mem,
    input  logic             dmem_ack,
    input  logic             imem_ready,
    input  logic             trap_wb,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_exe,
    output logic             stall_mem,
    output logic             stall_wb,
    output logic             flush_id,
    output logic             flush_exe,
    output logic             flush_mem,
    output logic             flush_wb,
    output logic             redirect,
    output logic [1:0]       redirect_sel,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        DMEM_WAIT   = 2'd1,
        TRAP_SHADOW = 2'd2,
        IMEM_WAIT   = 2'd3
    } state_t;

    localparam logic [1:0] SEL_NONE   = 2'd0;
    localparam logic [1:0] SEL_BRANCH = 2'd1;
    localparam logic [1:0] SEL_TRAP   = 2'd2;

    state_t state, state_next;

    logic dmem_stall;
    logic load_use;
    logic csr_hazard;

    // The ack cycle itself is a normal advance, so a pending mispredict falls through to it.
    assign dmem_stall = ~dmem_ack & ((state == DMEM_WAIT) | (dmem_req_mem & valid_mem));

    assign load_use = is_load_exe & valid_exe & (rd_exe != 5'd0) &
                      ((rs1_used_id & (rs1_id == rd_exe)) |
                       (rs2_used_id & (rs2_id == rd_exe)));

    assign csr_hazard = we_csr_id & ((we_csr_exe & valid_exe) | (we_csr_mem & valid_mem));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = RUN;
        stall_if     = 1'b0;
        stall_id     = 1'b0;
        stall_exe    = 1'b0;
        stall_mem    = 1'b0;
        stall_wb     = 1'b0;
        flush_id     = 1'b0;
        flush_exe    = 1'b0;
        flush_mem    = 1'b0;
        flush_wb     = 1'b0;
        redirect     = 1'b0;
        redirect_sel = SEL_NONE;

        if (rst) begin
            state_next = RUN;
        end else if (trap_wb) begin
            flush_id     = 1'b1;
            flush_exe    = 1'b1;
            flush_mem    = 1'b1;
            flush_wb     = 1'b1;
            redirect     = 1'b1;
            redirect_sel = SEL_TRAP;
            state_next   = TRAP_SHADOW;
        end else if (state == TRAP_SHADOW) begin
            // Kills the fetch that was already in flight when the trap redirected the PC.
            flush_id   = 1'b1;
            state_next = RUN;
        end else if (dmem_stall) begin
            stall_if   = 1'b1;
            stall_id   = 1'b1;
            stall_exe  = 1'b1;
            stall_mem  = 1'b1;
            flush_wb   = 1'b1;
            state_next = DMEM_WAIT;
        end else if (mispredict_exe & valid_exe) begin
            flush_id     = 1'b1;
            flush_exe    = 1'b1;
            redirect     = 1'b1;
            redirect_sel = SEL_BRANCH;
        end else if (load_use | csr_hazard) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            flush_exe = 1'b1;
        end else if (~imem_ready) begin
            stall_if   = 1'b1;
            flush_id   = 1'b1;
            state_next = IMEM_WAIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_if) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and pipeline-control unit for the five-stage RV64 core. It generates the per-stage `stall`/`flush` controls consumed by the IF/ID, ID/EXE, EXE/MEM and MEM/WB stage registers. It detects load-use and CSR hazards, waits on instruction and data memory handshakes, handles branch mispredicts resolved in EXE, and handles traps/returns committed in WB. It also holds a small FSM for multi-cycle memory waits and the post-trap flush shadow.

## Interface
Parameters
- `CNT_W`, 32, width of the stall-cycle performance counter.

Ports
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `rs1_id`, `rs2_id`  in  5 each  source register indices of the instruction in ID
- `rs1_used_id`, `rs2_used_id`  in  1 each  the ID instruction reads that source
- `we_csr_id`  in  1  the ID instruction is a CSR access
- `valid_exe`, `is_load_exe`, `we_csr_exe`  in  1 each  EXE-stage status
- `rd_exe`  in  5  EXE destination register
- `mispredict_exe`  in  1  EXE resolved `npc != predict_pc`
- `valid_mem`, `we_csr_mem`  in  1 each  MEM-stage status
- `dmem_req_mem`  in  1  MEM stage is issuing a load/store
- `dmem_ack`  in  1  data memory has completed the access this cycle
- `imem_ready`  in  1  instruction memory is returning a fetch this cycle
- `trap_wb`  in  1  exception or `mret`/`sret` is committing in WB
- `stall_if`, `stall_id`, `stall_exe`, `stall_mem`, `stall_wb`  out  1 each  hold the PC / the IF/ID, ID/EXE, EXE/MEM, MEM/WB registers
- `flush_id`, `flush_exe`, `flush_mem`, `flush_wb`  out  1 each  load a bubble into the IF/ID, ID/EXE, EXE/MEM, MEM/WB registers
- `redirect`  out  1  the PC takes a non-sequential target this cycle
- `redirect_sel`  out  2  0 = none, 1 = branch target from EXE, 2 = trap/CSR target
- `stall_cnt`  out  `CNT_W`  count of cycles with `stall_if` high

## Operation
- State register takes four values: `RUN`, `DMEM_WAIT`, `TRAP_SHADOW`, `IMEM_WAIT`.
- Invariant: `stall_X` and `flush_X` are never both high for the same register, because stage registers ignore flush while stalled. Bubbles are inserted only into an advancing register.
- Events are evaluated in fixed priority, highest first:
  1. `trap_wb`: flush_id/exe/mem/wb = 1; all stalls = 0; `redirect` = 1 with `redirect_sel` = 2; next state `TRAP_SHADOW`.
  2. `TRAP_SHADOW` (exactly one cycle): flush_id = 1, which kills the fetch issued before the redirect. The other flushes and all stalls are 0. Next state `RUN`.
  3. DMEM wait, raised when `dmem_req_mem & ~dmem_ack & valid_mem` or when the state is `DMEM_WAIT`:
     - stall_if/id/exe/mem = 1 and flush_wb = 1.
     - The state stays `DMEM_WAIT` until the cycle `dmem_ack` = 1. That cycle is a normal advance, and the next state is `RUN`.
     - A `mispredict_exe` raised during the wait is deferred. It is acted on the first cycle the wait is released.
  4. `mispredict_exe & valid_exe`: flush_id = flush_exe = 1; `redirect` = 1 with `redirect_sel` = 1; no stalls.
  5. Load-use hazard, raised when `is_load_exe & valid_exe & rd_exe != 0` and (`rs1_used_id & rs1_id == rd_exe` or `rs2_used_id & rs2_id == rd_exe`): stall_if = stall_id = 1 and flush_exe = 1 (one bubble).
  6. CSR serialization, raised when `we_csr_id` and (`we_csr_exe & valid_exe` or `we_csr_mem & valid_mem`): same action as the load-use hazard. It repeats until the older CSR op has left MEM.
  7. IMEM wait, raised when `~imem_ready`: stall_if = 1 and flush_id = 1. The state is `IMEM_WAIT` while this persists and returns to `RUN` on `imem_ready`.
- When no event is active, all outputs are 0.
- A register index of `x0` never causes a hazard.
- `stall_cnt` increments by 1 each cycle `stall_if` is high, wraps modulo 2^`CNT_W`, and is reset to 0.

## Timing
- All stall/flush/redirect outputs are combinational in the current inputs and state, so they take effect at the next `posedge clk` in the stage registers.
- The state register and `stall_cnt` update on `posedge clk`.
- Reset: state = `RUN`, `stall_cnt` = 0. While `rst` is high, all stall/flush/redirect outputs are 0 and `redirect_sel` = 0.
- Reset asserted mid-wait or in `TRAP_SHADOW` abandons the pending action. There is no deferred mispredict after reset.
- Load-use costs exactly 1 bubble. A branch mispredict costs 2 flushed slots. A trap costs 4 flushed slots plus 1 shadow slot.
- If `trap_wb` and `dmem_ack` are both high in the same cycle, the trap wins and the state becomes `TRAP_SHADOW`.
- If `trap_wb` arrives during `DMEM_WAIT`, the wait is abandoned.

## Test plan
- Load-use: `lw x5` in EXE with `rs1_id` = 5 in ID → exactly one cycle with stall_if = stall_id = flush_exe = 1, then all outputs 0. The same case with `rd_exe` = 0 → no stall.
- DMEM wait: `dmem_req_mem` = 1 with `dmem_ack` low for 3 cycles → stall_if..stall_mem = 1 and flush_wb = 1 for 3 cycles. `stall_cnt` advances by 3. On the ack cycle all outputs are 0.
- Mispredict deferred behind a DMEM wait: `mispredict_exe` = 1 throughout a 2-cycle wait → `redirect` stays 0 until the ack cycle. On the ack cycle `redirect` = 1 with `redirect_sel` = 1 and flush_id = flush_exe = 1.
- Trap: a `trap_wb` pulse → cycle t has all four flushes high, `redirect_sel` = 2. Cycle t+1 has only flush_id = 1. Cycle t+2 has all outputs 0.
- CSR serialization: a `csrrw` in ID with `we_csr_exe` = 1 → bubbles for 2 cycles, until the older op leaves MEM.
- Reset mid-`DMEM_WAIT` → the next cycle has state `RUN`, all outputs 0, and `stall_cnt` = 0.
